// File: rtl/depth_buffer_writer.sv
// depth_buffer_writer
//
// Depth-tested pixel writer for a framebuffer with an external depth RAM.
// Pixels stream in one per cycle, the stored depth is read (2-cycle RAM
// latency), the incoming depth is compared (strictly nearer wins) and on a
// pass both the depth RAM and the framebuffer are written. A clear pass
// fills the depth RAM with the farthest value and the framebuffer with
// CLEAR_COLOR, one address per cycle.
//
// Ports
//   clk_in, rst_in            clock, synchronous active-high reset
//   valid_in / ready_out      pixel-stream handshake
//   addr_in, z_in, color_in   pixel address, depth (smaller is nearer), colour
//   last_pixel_in             marks the final pixel of a frame
//   clear_in                  request a buffer clear
//   zb_rd_addr_out            depth RAM read address (combinational)
//   zb_rd_data_in             depth RAM read data, two cycles after address
//   zb_we_out, zb_wr_addr_out, zb_wr_data_out   depth RAM write port
//   fb_we_out, fb_addr_out, fb_data_out         framebuffer write port
//   frame_done_out            one-cycle pulse when the last pixel retires
//   busy_out                  clear/drain in progress or pixels in flight
//   pixels_drawn_out          depth-test passes since the last clear
module depth_buffer_writer #(
    parameter int FB_HRES     = 320,
    parameter int FB_VRES     = 180,
    parameter int Z_WIDTH     = 20,
    parameter int COLOR_WIDTH = 16,
    parameter logic [COLOR_WIDTH-1:0] CLEAR_COLOR = '0,
    localparam int NPIX = FB_HRES * FB_VRES,
    localparam int AW   = $clog2(NPIX)
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   valid_in,
    output logic                   ready_out,
    input  logic [AW-1:0]          addr_in,
    input  logic [Z_WIDTH-1:0]     z_in,
    input  logic [COLOR_WIDTH-1:0] color_in,
    input  logic                   last_pixel_in,
    input  logic                   clear_in,
    output logic [AW-1:0]          zb_rd_addr_out,
    input  logic [Z_WIDTH-1:0]     zb_rd_data_in,
    output logic                   zb_we_out,
    output logic [AW-1:0]          zb_wr_addr_out,
    output logic [Z_WIDTH-1:0]     zb_wr_data_out,
    output logic                   fb_we_out,
    output logic [AW-1:0]          fb_addr_out,
    output logic [COLOR_WIDTH-1:0] fb_data_out,
    output logic                   frame_done_out,
    output logic                   busy_out,
    output logic [AW:0]            pixels_drawn_out
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
    localparam logic [AW:0]   DRAWN_MAX = (AW + 1)'(NPIX);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic logic [AW:0] sat_inc(input logic [AW:0] v);
        return (v >= DRAWN_MAX) ? v : v + (AW + 1)'(1);
    endfunction

    state_t state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic [AW:0]   drawn_q, drawn_d;

    logic vld_p1_q, vld_p2_q, vld_p3_q;
    logic pass_p3_q;

    logic [AW-1:0]          addr_p1_q, addr_p2_q, addr_p3_q;
    logic [Z_WIDTH-1:0]     z_p1_q, z_p2_q, z_p3_q;
    logic [COLOR_WIDTH-1:0] color_p1_q, color_p2_q, color_p3_q;
    logic                   last_p1_q, last_p2_q, last_p3_q;

    logic accept;
    logic hazard;
    logic in_flight;
    logic depth_pass_p2;
    logic pix_we;

    // A pixel must not read an address whose earlier write has not landed.
    assign hazard = (vld_p1_q && (addr_p1_q == addr_in)) ||
                    (vld_p2_q && (addr_p2_q == addr_in)) ||
                    (vld_p3_q && (addr_p3_q == addr_in));

    assign ready_out = !rst_in && (state_q == ST_RUN) && !hazard;
    assign accept    = valid_in && ready_out;

    // Pixels that still have a write ahead of them after this cycle; the
    // stage-3 pixel finishes its write in the current cycle.
    assign in_flight = accept || vld_p1_q || vld_p2_q;

    assign zb_rd_addr_out = addr_in;
    assign depth_pass_p2  = z_p2_q < zb_rd_data_in;
    assign pix_we         = vld_p3_q && pass_p3_q;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + AW'(1);
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d   = ST_RUN;
                    clr_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (clear_in) begin
                    state_d = in_flight ? ST_DRAIN : ST_CLEAR;
                end
            end
            ST_DRAIN: begin
                if (!vld_p1_q && !vld_p2_q) begin
                    state_d = ST_CLEAR;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_comb begin
        drawn_d = drawn_q;
        if (pix_we) begin
            drawn_d = sat_inc(drawn_q);
        end
        // Entering a clear wins over a pass retiring in the same cycle.
        if ((state_q != ST_CLEAR) && (state_d == ST_CLEAR)) begin
            drawn_d = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            drawn_q   <= '0;
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            vld_p3_q  <= 1'b0;
            pass_p3_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            drawn_q   <= drawn_d;
            vld_p1_q  <= accept;
            vld_p2_q  <= vld_p1_q;
            vld_p3_q  <= vld_p2_q;
            pass_p3_q <= vld_p2_q && depth_pass_p2;
        end
    end

    always_ff @(posedge clk_in) begin
        // p1: pixel captured, depth RAM read in flight
        addr_p1_q  <= addr_in;
        z_p1_q     <= z_in;
        color_p1_q <= color_in;
        last_p1_q  <= last_pixel_in;
        // p2: stored depth arrives, compare
        addr_p2_q  <= addr_p1_q;
        z_p2_q     <= z_p1_q;
        color_p2_q <= color_p1_q;
        last_p2_q  <= last_p1_q;
        // p3: write-back
        addr_p3_q  <= addr_p2_q;
        z_p3_q     <= z_p2_q;
        color_p3_q <= color_p2_q;
        last_p3_q  <= last_p2_q;
    end

    always_comb begin
        zb_we_out      = 1'b0;
        zb_wr_addr_out = '0;
        zb_wr_data_out = '0;
        fb_we_out      = 1'b0;
        fb_addr_out    = '0;
        fb_data_out    = '0;
        if (!rst_in) begin
            if (state_q == ST_CLEAR) begin
                zb_we_out      = 1'b1;
                zb_wr_addr_out = clr_cnt_q;
                zb_wr_data_out = '1;
                fb_we_out      = 1'b1;
                fb_addr_out    = clr_cnt_q;
                fb_data_out    = CLEAR_COLOR;
            end else if (pix_we) begin
                zb_we_out      = 1'b1;
                zb_wr_addr_out = addr_p3_q;
                zb_wr_data_out = z_p3_q;
                fb_we_out      = 1'b1;
                fb_addr_out    = addr_p3_q;
                fb_data_out    = color_p3_q;
            end
        end
    end

    assign frame_done_out   = !rst_in && vld_p3_q && last_p3_q;
    assign busy_out         = rst_in || (state_q != ST_RUN) ||
                              vld_p1_q || vld_p2_q || vld_p3_q;
    assign pixels_drawn_out = rst_in ? '0 : drawn_q;

endmodule

// File: tb/tb_depth_buffer_writer.sv
module tb_depth_buffer_writer;

    localparam int NPIX = 8;
    localparam int AW   = 3;
    localparam logic [15:0] CC = 16'hC1EA;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic [2:0]  addr_in = '0;
    logic [7:0]  z_in = '0;
    logic [15:0] color_in = '0;
    logic        last_pixel_in = 1'b0;
    logic        clear_in = 1'b0;
    logic [2:0]  zb_rd_addr_out;
    logic [7:0]  zb_rd_data_in;
    logic        zb_we_out;
    logic [2:0]  zb_wr_addr_out;
    logic [7:0]  zb_wr_data_out;
    logic        fb_we_out;
    logic [2:0]  fb_addr_out;
    logic [15:0] fb_data_out;
    logic        frame_done_out;
    logic        busy_out;
    logic [3:0]  pixels_drawn_out;

    always #5 clk = ~clk;

    depth_buffer_writer #(
        .FB_HRES(4), .FB_VRES(2), .Z_WIDTH(8), .COLOR_WIDTH(16), .CLEAR_COLOR(CC)
    ) dut (
        .clk_in(clk), .rst_in(rst_in),
        .valid_in(valid_in), .ready_out(ready_out),
        .addr_in(addr_in), .z_in(z_in), .color_in(color_in),
        .last_pixel_in(last_pixel_in), .clear_in(clear_in),
        .zb_rd_addr_out(zb_rd_addr_out), .zb_rd_data_in(zb_rd_data_in),
        .zb_we_out(zb_we_out), .zb_wr_addr_out(zb_wr_addr_out),
        .zb_wr_data_out(zb_wr_data_out),
        .fb_we_out(fb_we_out), .fb_addr_out(fb_addr_out), .fb_data_out(fb_data_out),
        .frame_done_out(frame_done_out), .busy_out(busy_out),
        .pixels_drawn_out(pixels_drawn_out)
    );

    // Depth RAM: read data appears two cycles after the address.
    logic [7:0] zmem [NPIX];
    logic [7:0] rd1, rd2;
    always @(posedge clk) begin
        if (zb_we_out) zmem[zb_wr_addr_out] <= zb_wr_data_out;
        rd1 <= zmem[zb_rd_addr_out];
        rd2 <= rd1;
    end
    assign zb_rd_data_in = rd2;

    // Reference model: expected write/frame-done per absolute cycle number.
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int cs = 1 << 30;      // first cycle of the most recently scheduled clear
    int L = -100;          // cycle of the most recent accepted pixel
    int drawn = 0;
    int done_cnt = 0;
    bit last_acc = 1'b0;
    logic [7:0] refz [NPIX];
    bit          ev_we   [int];
    logic [2:0]  ev_addr [int];
    logic [7:0]  ev_z    [int];
    logic [15:0] ev_col  [int];
    bit          ev_done [int];
    logic [2:0]  acc_addr [int];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit hazard(input logic [2:0] a);
        for (int k = 1; k <= 3; k++) begin
            if (acc_addr.exists(cyc - k) && acc_addr[cyc - k] == a) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic sched_clear(input int s);
        cs = s;
        for (int k = 0; k < NPIX; k++) begin
            ev_we[s + k]   = 1'b1;
            ev_addr[s + k] = 3'(k);
            ev_z[s + k]    = 8'hFF;
            ev_col[s + k]  = CC;
            ev_done[s + k] = 1'b0;
            refz[k]        = 8'hFF;
        end
    endtask

    task automatic cycle();
        logic [32:0] ob_v, ev_v;
        bit r, rdy_e, busy_e, acc, pass_e;
        @(negedge clk);
        r = rst_in;
        ob_v = {zb_we_out, fb_we_out, zb_wr_addr_out, zb_wr_data_out,
                fb_addr_out, fb_data_out, frame_done_out};
        if (frame_done_out) done_cnt++;
        ev_v = '0;
        if (r) begin
            rdy_e  = 1'b0;
            busy_e = 1'b1;
        end else begin
            if (ev_we.exists(cyc)) begin
                if (ev_we[cyc])
                    ev_v = {2'b11, ev_addr[cyc], ev_z[cyc], ev_addr[cyc], ev_col[cyc], ev_done[cyc]};
                else
                    ev_v[0] = ev_done[cyc];
            end
            rdy_e  = (cyc >= cs + NPIX) && !hazard(addr_in);
            busy_e = (cyc < cs + NPIX) || (L >= cyc - 3);
            if (valid_in) chk("rd_addr", 64'(zb_rd_addr_out), 64'(addr_in));
        end
        chk("writes", 64'(ob_v), 64'(ev_v));
        chk("ready", 64'(ready_out), 64'(rdy_e));
        chk("busy", 64'(busy_out), 64'(busy_e));
        chk("drawn", 64'(pixels_drawn_out), r ? 64'(0) : 64'(drawn));
        acc = !r && valid_in && rdy_e;
        last_acc = acc;
        if (acc) begin
            pass_e = z_in < refz[addr_in];
            if (pass_e) refz[addr_in] = z_in;
            acc_addr[cyc]     = addr_in;
            L                 = cyc;
            ev_we[cyc + 3]    = pass_e;
            ev_addr[cyc + 3]  = addr_in;
            ev_z[cyc + 3]     = z_in;
            ev_col[cyc + 3]   = color_in;
            ev_done[cyc + 3]  = last_pixel_in;
        end
        if (!r && clear_in && cyc >= cs + NPIX)
            sched_clear((cyc + 1 > L + 4) ? cyc + 1 : L + 4);
        @(posedge clk);
        #1;
        if (r) begin
            ev_we.delete(); ev_addr.delete(); ev_z.delete();
            ev_col.delete(); ev_done.delete(); acc_addr.delete();
            L = -100;
            drawn = 0;
            sched_clear(cyc + 1);
        end else if (ev_we.exists(cyc) && ev_we[cyc] && !(cyc >= cs && cyc < cs + NPIX)) begin
            drawn = (drawn >= NPIX) ? NPIX : drawn + 1;
        end
        if (cyc + 1 == cs) drawn = 0;
        cyc++;
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0; clear_in = 1'b0; last_pixel_in = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic send(input logic [2:0] a, input logic [7:0] z, input logic [15:0] c,
                        input bit last, input bit clr, output int waits);
        valid_in = 1'b1; addr_in = a; z_in = z; color_in = c;
        last_pixel_in = last; clear_in = clr;
        waits = 0;
        cycle();
        while (!last_acc && waits < 40) begin
            waits++;
            cycle();
        end
        chk("accepted", 64'(last_acc), 64'(1));
        valid_in = 1'b0; last_pixel_in = 1'b0; clear_in = 1'b0;
    endtask

    initial begin
        int w, d0, n;
        // Reset, then the full power-up clear followed by idle RUN.
        rst_in = 1'b1;
        idle(3);
        rst_in = 1'b0;
        idle(10);

        // Single pixel passes against the cleared depth.
        send(3'd3, 8'h40, 16'h1234, 1'b0, 1'b0, w);
        idle(4);
        chk("drawn_first", 64'(pixels_drawn_out), 64'(1));

        // Farther and equal depths both fail.
        send(3'd3, 8'h50, 16'h5555, 1'b0, 1'b0, w);
        idle(4);
        send(3'd3, 8'h40, 16'h6666, 1'b0, 1'b0, w);
        idle(4);
        chk("drawn_after_fails", 64'(pixels_drawn_out), 64'(1));

        // Same-address back-to-back stalls three cycles, then passes.
        send(3'd5, 8'h30, 16'hAAAA, 1'b0, 1'b0, w);
        send(3'd5, 8'h20, 16'hBBBB, 1'b0, 1'b0, w);
        chk("hazard_stall", 64'(w), 64'(3));
        idle(4);
        chk("zmem5", 64'(zmem[5]), 64'(8'h20));

        // Frame stream with a clear request alongside address 6.
        d0 = done_cnt;
        for (int i = 0; i < NPIX; i++) begin
            send(3'(i), 8'(8'h10 + i), 16'(16'h0100 + i), i == 7, i == 6, w);
            if (i == 7) chk("drawn_after_clear", 64'(pixels_drawn_out), 64'(0));
        end
        idle(6);
        chk("frame_done_once", 64'(done_cnt - d0), 64'(1));

        // Randomised traffic with occasional clears, frame ends and resets.
        for (int i = 0; i < 400; i++) begin
            valid_in      = ($urandom_range(0, 9) < 7);
            addr_in       = 3'($urandom_range(0, 7));
            z_in          = 8'($urandom_range(0, 255));
            color_in      = 16'($urandom);
            last_pixel_in = ($urandom_range(0, 15) == 0);
            clear_in      = ($urandom_range(0, 79) == 0);
            rst_in        = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst_in = 1'b0;
        idle(20);

        // Reset in the middle of a clear restarts it from address 0.
        clear_in = 1'b1;
        cycle();
        clear_in = 1'b0;
        n = 0;
        while (cyc != cs + 4 && n < 40) begin
            cycle();
            n++;
        end
        chk("reach_clear_addr4", 64'(cyc), 64'(cs + 4));
        rst_in = 1'b1;
        cycle();
        rst_in = 1'b0;
        idle(12);

        // Final depth RAM contents against the model.
        for (int i = 0; i < NPIX; i++) chk("zmem_final", 64'(zmem[i]), 64'(refz[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
